// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_pkg
//  Description : Shared UART bit-timing constants and receiver state encoding
//                for the serial I/O blocks (receive and transmit sides).
//  Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    // 10 MHz clock at 115200 baud
    localparam int c_UART_CLKS_PER_BIT = 87;
    localparam int c_UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    // Last count of the half-bit wait that lands the sampler at bit centre.
    function automatic int half_bit_last(input int clks_per_bit);
        return (clks_per_bit >= 2) ? (clks_per_bit / 2) - 1 : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_loader_if
//  Description : BRAM port-A write bus (address, data, one-cycle strobe).
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_loader_if;

    logic [15:0] addr_io;
    logic [15:0] data_out_io;
    logic        we_io;

    modport master (output addr_io, output data_out_io, output we_io);
    modport slave  (input  addr_io, input  data_out_io, input  we_io);

endinterface
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART byte receiver: two-flop synchronizer, start-bit
//                glitch rejection, centre sampling, LSB-first shift register.
//                Dropping enable aborts any frame in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_UART_CLKS_PER_BIT
) (
    input  wire logic       clk_100,
    input  wire logic       rst_n,
    input  wire logic       rx,
    input  wire logic       enable,
    output logic [7:0]      byte_data,
    output logic            byte_valid,
    output logic            stop_err
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(half_bit_last(CLKS_PER_BIT));
    localparam logic [2:0]         c_LAST_BIT  = 3'(c_UART_DATA_BITS - 1);

    logic               r_rx_meta;
    logic               r_rx_sync;
    rx_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_valid;
    logic               r_stop_err;

    // Bring the asynchronous line into the clock domain; resets to idle-high.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Frame receiver: start check at half bit, then one sample per bit time.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= R_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_valid    <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_stop_err <= 1'b0;
            if (!enable) begin
                r_state <= R_IDLE;
                r_cnt   <= '0;
                r_bit   <= '0;
            end else begin
                case (r_state)
                    R_IDLE: begin
                        if (!r_rx_sync) begin
                            r_state <= R_START;
                            r_cnt   <= '0;
                        end
                    end
                    R_START: begin
                        if (r_cnt == c_HALF_LAST) begin
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            // A line that is high again by mid-start was a glitch.
                            r_state <= r_rx_sync ? R_IDLE : R_DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    R_DATA: begin
                        if (r_cnt == c_FULL_LAST) begin
                            r_cnt   <= '0;
                            r_shift <= {r_rx_sync, r_shift[7:1]};
                            if (r_bit == c_LAST_BIT) begin
                                r_state <= R_STOP;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    R_STOP: begin
                        if (r_cnt == c_FULL_LAST) begin
                            r_cnt   <= '0;
                            r_state <= R_IDLE;
                            if (r_rx_sync) begin
                                r_valid <= 1'b1;
                            end else begin
                                r_stop_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= R_IDLE;
                    end
                endcase
            end
        end
    end

    assign byte_data  = r_shift;
    assign byte_valid = r_valid;
    assign stop_err   = r_stop_err;

endmodule
`default_nettype wire

// File: rtl/bram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bram_loader
//  Description : Loads LOAD_WORDS big-endian 16-bit words received over UART
//                into BRAM port A, starting at address 0. Load is gated by
//                the ctrl_io_receive level; dropping it aborts and rewinds.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_loader
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_UART_CLKS_PER_BIT,
    parameter int LOAD_WORDS   = 256
) (
    input  wire logic     clk_100,
    input  wire logic     rst_n,
    input  wire logic     rx,
    input  wire logic     ctrl_io_receive,
    bram_loader_if.master bram,
    output logic          busy,
    output logic          done,
    output logic          frame_err,
    output logic          led_rx
);

    // Address of the final word; 16-bit wrap makes a 65536-word load work.
    localparam logic [15:0] c_LAST_ADDR = 16'(LOAD_WORDS - 1);

    logic [7:0]  w_byte_data;
    logic        w_byte_valid;
    logic        w_stop_err;
    logic        w_rx_enable;

    logic        r_ctrl_d;
    logic        r_busy;
    logic        r_done;
    logic        r_frame_err;
    logic        r_have_hi;
    logic [7:0]  r_hi;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_we;
    logic        r_we_d;

    // Receiver only runs during a load; enable low doubles as the abort.
    assign w_rx_enable = r_busy & ctrl_io_receive;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_100    (clk_100),
        .rst_n      (rst_n),
        .rx         (rx),
        .enable     (w_rx_enable),
        .byte_data  (w_byte_data),
        .byte_valid (w_byte_valid),
        .stop_err   (w_stop_err)
    );

    // Load control, byte pairing and address sequencing; abort has priority.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_have_hi <= 1'b0;
            r_hi      <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_we_d    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (!ctrl_io_receive) begin
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_have_hi <= 1'b0;
                r_addr    <= '0;
                r_we_d    <= 1'b0;
            end else begin
                r_we_d <= r_we;
                if (!r_busy && !r_done) begin
                    r_busy <= 1'b1;
                end
                if (r_busy && w_byte_valid) begin
                    if (!r_have_hi) begin
                        r_hi      <= w_byte_data;
                        r_have_hi <= 1'b1;
                    end else begin
                        r_data    <= {r_hi, w_byte_data};
                        r_we      <= 1'b1;
                        r_have_hi <= 1'b0;
                    end
                end
                // Address still holds the written word's location during r_we.
                if (r_we && (r_addr == c_LAST_ADDR)) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                // Advance only after the address has been held for two cycles.
                if (r_we_d) begin
                    r_addr <= r_addr + 16'd1;
                end
            end
        end
    end

    // Sticky framing error, cleared when a new load is requested.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_d    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_ctrl_d <= ctrl_io_receive;
            if (ctrl_io_receive && !r_ctrl_d) begin
                r_frame_err <= 1'b0;
            end else if (w_stop_err && ctrl_io_receive) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign bram.addr_io     = r_addr;
    assign bram.data_out_io = r_data;
    assign bram.we_io       = r_we;
    assign busy             = r_busy;
    assign done             = r_done;
    assign frame_err        = r_frame_err;
    assign led_rx           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_loader
//  Description : Self-checking bench for bram_loader: directed load scenarios
//                plus randomized byte/abort/error/glitch traffic against a
//                word-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_loader;

    localparam int CPB = 8;
    localparam int LW  = 2;

    logic clk_100 = 1'b0;
    logic rst_n   = 1'b0;
    logic rx      = 1'b1;
    logic ctrl    = 1'b0;
    logic busy, done, frame_err, led_rx;

    bram_loader_if bram ();

    bram_loader #(
        .CLKS_PER_BIT (CPB),
        .LOAD_WORDS   (LW)
    ) dut (
        .clk_100         (clk_100),
        .rst_n           (rst_n),
        .rx              (rx),
        .ctrl_io_receive (ctrl),
        .bram            (bram),
        .busy            (busy),
        .done            (done),
        .frame_err       (frame_err),
        .led_rx          (led_rx)
    );

    always #5 clk_100 = ~clk_100;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: load state at word/byte granularity.
    bit          m_en;
    bit          m_done;
    bit          m_have_hi;
    logic [7:0]  m_hi;
    int          m_count;
    bit          m_ferr;
    logic [31:0] exp_q[$];   // {addr, data} writes still expected
    logic [31:0] got_q[$];   // every write seen on the bus

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_done = 0; m_have_hi = 0; m_hi = '0; m_count = 0; m_ferr = 0;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
        if (!(m_en && !m_done)) return;
        if (!stop_ok) begin
            m_ferr = 1;
            return;
        end
        if (!m_have_hi) begin
            m_hi = b;
            m_have_hi = 1;
        end else begin
            exp_q.push_back({16'(m_count), m_hi, b});
            m_have_hi = 0;
            m_count++;
            if (m_count == LW) m_done = 1;
        end
    endfunction

    // Bus monitor: every write must be the next expected one and the bus must
    // hold address/data for the cycle after the strobe.
    logic        prev_we = 1'b0;
    logic [15:0] prev_addr, prev_data;
    always @(negedge clk_100) begin
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (prev_we) begin
                chk("we_width", 32'(bram.we_io), 32'd0);
                chk("addr_hold", 32'(bram.addr_io), 32'(prev_addr));
                chk("data_hold", 32'(bram.data_out_io), 32'(prev_data));
            end
            if (bram.we_io && !prev_we) begin
                got_q.push_back({bram.addr_io, bram.data_out_io});
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("write_addr_data", {bram.addr_io, bram.data_out_io}, exp_q.pop_front());
                end
            end
            prev_we   = bram.we_io;
            prev_addr = bram.addr_io;
            prev_data = bram.data_out_io;
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk_100);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        rx = 1'b1;
        repeat (CPB + 2 + $urandom_range(0, 3)) @(posedge clk_100);
        #1;
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (3) @(posedge clk_100);
        #1;
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk_100);
        #1;
    endtask

    task automatic set_enable(input bit v);
        if (v && !m_en) m_ferr = 0;
        if (!v) begin
            m_have_hi = 0; m_count = 0; m_done = 0;
        end
        m_en = v;
        ctrl = v;
        repeat (3) @(posedge clk_100);
        #1;
    endtask

    task automatic check_status(input string tag);
        logic        eb;
        logic [15:0] ea;
        eb = m_en && !m_done;
        ea = m_done ? 16'(LW % 65536) : 16'(m_count);
        @(negedge clk_100);
        chk({tag, ":busy"}, 32'(busy), 32'(eb));
        chk({tag, ":led_rx"}, 32'(led_rx), 32'(eb));
        chk({tag, ":done"}, 32'(done), 32'(m_done));
        chk({tag, ":frame_err"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, ":addr"}, 32'(bram.addr_io), 32'(ea));
        chk({tag, ":pending_writes"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk_100);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ":addr"}, 32'(bram.addr_io), 32'd0);
        chk({tag, ":data"}, 32'(bram.data_out_io), 32'd0);
        chk({tag, ":we"}, 32'(bram.we_io), 32'd0);
        chk({tag, ":busy"}, 32'(busy), 32'd0);
        chk({tag, ":done"}, 32'(done), 32'd0);
        chk({tag, ":frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, ":led_rx"}, 32'(led_rx), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int base;
        int op;
        rx    = 1'b1;
        ctrl  = 1'b1;
        rst_n = 1'b0;
        m_en  = 1;
        model_reset();
        repeat (3) @(posedge clk_100);
        #1;
        check_reset_outputs("reset");

        // Enable already high when reset releases: load starts by itself.
        rst_n = 1'b1;
        repeat (3) @(posedge clk_100);
        #1;
        chk("post_reset_busy", 32'(busy), 32'd1);
        check_status("post_reset");

        // Two-word load.
        base = got_q.size();
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'hAB, 1); send_byte(8'hCD, 1);
        check_status("load2");
        chk("load2_nwrites", 32'(got_q.size() - base), 32'd2);
        chk("load2_w0", got_q[base], 32'h0000_1234);
        chk("load2_w1", got_q[base + 1], 32'h0001_ABCD);
        chk("load2_done", 32'(done), 32'd1);
        chk("load2_busy", 32'(busy), 32'd0);

        // Traffic after completion is ignored.
        base = got_q.size();
        send_byte(8'h55, 1);
        check_status("after_done");
        chk("after_done_nwrites", 32'(got_q.size() - base), 32'd0);
        chk("after_done_addr", 32'(bram.addr_io), 32'd2);

        // Bad stop bit: flagged, byte discarded.
        set_enable(0); set_enable(1);
        base = got_q.size();
        send_byte(8'h12, 0);
        chk("ferr_set", 32'(frame_err), 32'd1);
        send_byte(8'h34, 1); send_byte(8'h56, 1);
        check_status("ferr");
        chk("ferr_w0", got_q[base], 32'h0000_3456);

        // Abort with a half word pending, then restart.
        set_enable(0); set_enable(1);
        base = got_q.size();
        send_byte(8'h12, 1);
        set_enable(0); set_enable(1);
        send_byte(8'h34, 1); send_byte(8'h56, 1);
        check_status("abort");
        chk("abort_nwrites", 32'(got_q.size() - base), 32'd1);
        chk("abort_w0", got_q[base], 32'h0000_3456);
        chk("abort_ferr", 32'(frame_err), 32'd0);

        // Short low pulse is not a start bit; receiver keeps working after it.
        base = got_q.size();
        glitch();
        check_status("glitch");
        send_byte(8'h9A, 1); send_byte(8'hBC, 1);
        check_status("post_glitch");
        chk("glitch_w1", got_q[base], 32'h0001_9ABC);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 11);
            if (op == 0) begin
                set_enable(0); set_enable(1);
            end else if (op == 1) begin
                set_enable(0);
                send_byte(8'($urandom), 1);
                set_enable(1);
            end else if (op == 2) begin
                send_byte(8'($urandom), 0);
            end else if (op == 3) begin
                glitch();
            end else begin
                send_byte(8'($urandom), 1);
            end
            check_status($sformatf("rand%0d", it));
        end

        // Asynchronous reset in the middle of a byte, then a clean load.
        set_enable(0); set_enable(1);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        #3;
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check_reset_outputs("midbyte_reset");
        model_reset();
        repeat (2) @(posedge clk_100);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_100);
        #1;
        check_status("after_midbyte_reset");
        base = got_q.size();
        send_byte(8'hDE, 1); send_byte(8'hAD, 1);
        send_byte(8'hBE, 1); send_byte(8'hEF, 1);
        check_status("reload");
        chk("reload_w0", got_q[base], 32'h0000_DEAD);
        chk("reload_w1", got_q[base + 1], 32'h0001_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per UART bit (10 MHz clock, 115200 baud).
REQ-002 The module SHALL have parameter LOAD_WORDS, default 256, meaning the number of 16-bit words per load (range 1..65536).
REQ-003 The module SHALL have input clk_100, 1 bit: the single clock, driven by the divided system clock.
REQ-004 The module SHALL have input rst_n, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have input rx, 1 bit: UART serial line, idle high, asynchronous to clk_100.
REQ-006 The module SHALL have input ctrl_io_receive, 1 bit: load enable level, from the mode switch.
REQ-007 The module SHALL have output addr_io, 16 bits: BRAM port-A write address.
REQ-008 The module SHALL have output data_out_io, 16 bits: BRAM port-A write data.
REQ-009 The module SHALL have output we_io, 1 bit: BRAM port-A write strobe, one cycle wide.
REQ-010 The module SHALL have output busy, 1 bit: high while a load is in progress.
REQ-011 The module SHALL have output done, 1 bit: high once LOAD_WORDS words have been written.
REQ-012 The module SHALL have output frame_err, 1 bit: sticky flag for a bad stop bit.
REQ-013 The module SHALL have output led_rx, 1 bit: high while busy.

Function
REQ-014 rx SHALL pass through a two-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-015 The receiver FSM SHALL have states R_IDLE, R_START, R_DATA and R_STOP.
REQ-016 Receiver transitions: R_IDLE→R_START on a synchronized rx low while busy; after CLKS_PER_BIT/2 cycles, R_START→R_DATA if rx is still low, otherwise R_START→R_IDLE (glitch rejected).
REQ-017 In R_DATA the receiver SHALL sample 8 bits, LSB first, one every CLKS_PER_BIT cycles at bit centre, then move to R_STOP.
REQ-018 In R_STOP, one bit-time later: rx high → byte valid for one cycle; rx low → byte discarded and frame_err set to 1. Both cases return to R_IDLE.
REQ-019 Packing: the first valid byte of each pair SHALL become data_out_io[15:8] and the second data_out_io[7:0] (big-endian).
REQ-020 we_io SHALL pulse for exactly one cycle, the cycle after the second byte is valid.
REQ-021 addr_io and data_out_io SHALL be stable during the we_io cycle and the cycle after it.
REQ-022 addr_io SHALL increment by 1 in the cycle after each we_io; the first word of a load SHALL be written to address 0.
REQ-023 busy SHALL rise in the cycle after ctrl_io_receive is sampled high while done=0.
REQ-024 When the LOAD_WORDS-th write occurs, done SHALL rise and busy fall in the following cycle. Bytes received after that are ignored and generate no writes. addr_io holds LOAD_WORDS mod 65536.
REQ-025 ctrl_io_receive low at any time SHALL, on the next cycle: abort the receiver to R_IDLE, discard any partial byte or half-word, clear busy and done, and return addr_io to 0. A new load restarts at address 0.
REQ-026 frame_err SHALL clear only on reset or on a rising edge of ctrl_io_receive.
REQ-027 An ordering conflict between a write and an abort cannot arise: when abort and the second-byte-valid event fall in the same cycle, abort SHALL win and no we_io SHALL issue.

Reset
REQ-028 On rst_n low, asynchronously: receiver in R_IDLE, byte-pair flag cleared, addr_io=0, data_out_io=0, we_io=0, busy=0, done=0, frame_err=0, led_rx=0.
REQ-029 Synchronizer flops SHALL reset to 1 (line idle).
REQ-030 After rst_n deasserts with ctrl_io_receive already high, a load SHALL begin per REQ-023.

Structure
REQ-031 The UART bit-timing constants and receiver state encoding SHALL live in the shared package io_pkg, for reuse by the transmit side.
REQ-032 The serial receiver (synchronizer, FSM, bit counter, shift register) SHALL be a sub-module uart_rx_byte, with outputs byte_data[7:0] and byte_valid.
REQ-033 Packing, addressing and load control SHALL reside in bram_loader.

Verification
REQ-034 CLKS_PER_BIT=8, LOAD_WORDS=2, enable high; send 0x12, 0x34, 0xAB, 0xCD → we_io at addr 0 data 0x1234, then at addr 1 data 0xABCD; done=1, busy=0.
REQ-035 After done, send 0x55 → no we_io; addr_io stays 2.
REQ-036 Send 0x12 with the stop bit driven low → frame_err=1, no byte counted; then send 0x34, 0x56 → write 0x3456 at addr 0.
REQ-037 Send 0x12, drop enable, raise it again, send 0x34, 0x56 → single write 0x3456 at addr 0; frame_err=0.
REQ-038 Drive a 3-cycle low pulse on rx → no byte accepted; receiver back in R_IDLE.
REQ-039 Assert rst_n low mid-byte → all outputs take their REQ-028 values immediately; a subsequent clean load completes normally.
